// File: rtl/top_no_fifo_if.sv
// Streaming handshake bundle for top_no_fifo: upstream valid/data in, downstream valid/data out,
// ready in each direction.
interface top_no_fifo_if #(
   parameter int WIDTH = 8
);
   logic             valid_i;
   logic             ready_i;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             ready_o;
   logic             valid_o;

   modport master (
      output valid_i, ready_i, din,
      input  dout, ready_o, valid_o
   );

   modport slave (
      input  valid_i, ready_i, din,
      output dout, ready_o, valid_o
   );
endinterface

// File: rtl/top_no_fifo.sv
// Elastic pipeline of DEPTH skid-buffer stages. Latency is DEPTH-1 edges after accept, and a
// stage holds two words before its registered ready drops, so a stall absorbs 2*DEPTH words.
module top_no_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   top_no_fifo_if.slave bus
);
   logic [DEPTH-1:0] main_v;
   logic [DEPTH-1:0] skid_v;
   logic [WIDTH-1:0] main_d [DEPTH];
   logic [WIDTH-1:0] skid_d [DEPTH];

   // Chains indexed by stage: stage k sees upstream at [k] and downstream ready at [k+1].
   logic [DEPTH:0]   v_chain;
   logic [DEPTH:0]   r_chain;
   logic [WIDTH-1:0] d_chain [DEPTH+1];
   logic [DEPTH-1:0] take;
   logic [DEPTH-1:0] give;

   assign v_chain = {main_v, bus.valid_i};
   assign r_chain = {bus.ready_i, ~skid_v};
   assign take    = v_chain[DEPTH-1:0] & ~skid_v;
   assign give    = main_v & r_chain[DEPTH:1];

   always_comb begin
      d_chain[0] = bus.din;
      for (int k = 0; k < DEPTH; k++) begin
         d_chain[k+1] = main_d[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_v <= '0;
         skid_v <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            main_d[k] <= '0;
            skid_d[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!main_v[k] || give[k]) begin
               // Skid word has priority so order is preserved when main frees up.
               if (skid_v[k]) begin
                  main_v[k] <= 1'b1;
                  main_d[k] <= skid_d[k];
               end else begin
                  main_v[k] <= take[k];
                  if (take[k]) begin
                     main_d[k] <= d_chain[k];
                  end
               end
               skid_v[k] <= skid_v[k] && take[k];
               if (skid_v[k] && take[k]) begin
                  skid_d[k] <= d_chain[k];
               end
            end else if (take[k]) begin
               skid_v[k] <= 1'b1;
               skid_d[k] <= d_chain[k];
            end
         end
      end
   end

   assign bus.ready_o = r_chain[0];
   assign bus.valid_o = main_v[DEPTH-1];
   assign bus.dout    = main_d[DEPTH-1];
endmodule

// File: tb/tb_top_no_fifo.sv
// Bench for top_no_fifo (WIDTH=8, DEPTH=2): a queue holds every accepted word in order and
// each output transfer must pop exactly the head of that queue.
module tb_top_no_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int CAP   = 2 * DEPTH;

   logic clk;
   logic rst;
   top_no_fifo_if #(.WIDTH(WIDTH)) bus ();

   top_no_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int max_occ = 0;
   logic [WIDTH-1:0] sb [$];

   // One clock: sample both handshakes at the negedge, update the reference queue after the edge.
   task automatic tick(output bit acc, output bit fired, output logic [WIDTH-1:0] got,
                       output logic [WIDTH-1:0] exp, output bit orphan);
      logic [WIDTH-1:0] d;
      @(negedge clk);
      acc    = bus.valid_i && bus.ready_o;
      fired  = bus.valid_o && bus.ready_i;
      got    = bus.dout;
      d      = bus.din;
      orphan = bus.valid_o && (sb.size() == 0);
      exp    = 'x;
      @(posedge clk);
      #1;
      if (fired && sb.size() > 0) exp = sb.pop_front();
      if (acc) sb.push_back(d);
      if (sb.size() > max_occ) max_occ = sb.size();
   endtask

   task automatic test_reset();
      bit a, f, o;
      logic [WIDTH-1:0] g, e;
      rst = 1'b0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.din = '0;
      repeat (3) @(posedge clk);
      #2;
      tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid_o got=%b exp=0", bus.valid_o); end
      tests++; if (bus.dout !== '0) begin fails++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
      tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready_o got=%b exp=1", bus.ready_o); end
      @(negedge clk);
      rst = 1'b1;
      bus.ready_i = 1'b1;
      repeat (3) tick(a, f, g, e, o);
      tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_release_idle got=%b exp=0", bus.valid_o); end
   endtask

   task automatic test_streaming();
      bit a, f, o;
      logic [WIDTH-1:0] g, e;
      logic [WIDTH-1:0] cnt;
      cnt = '0;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b1;
      bus.din = cnt;
      tick(a, f, g, e, o);
      if (a) cnt++;
      bus.din = cnt;
      tests++; if (a !== 1'b1) begin fails++; $display("FAIL stream_first_accept got=%b exp=1", a); end
      tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL stream_latency_early got=%b exp=0", bus.valid_o); end
      tick(a, f, g, e, o);
      if (a) cnt++;
      bus.din = cnt;
      tests++; if (bus.valid_o !== 1'b1 || bus.dout !== 8'd0) begin
         fails++; $display("FAIL stream_first_out got=%b/%h exp=1/00", bus.valid_o, bus.dout);
      end
      for (int i = 0; i < 20; i++) begin
         tick(a, f, g, e, o);
         if (a) cnt++;
         bus.din = cnt;
         tests++; if (f !== 1'b1 || a !== 1'b1) begin fails++; $display("FAIL stream_bubble cyc=%0d fired=%b acc=%b exp=1/1", i, f, a); end
         tests++; if (g !== e) begin fails++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, g, e); end
      end
   endtask

   task automatic test_stall_release();
      bit a, f, o, have_ref;
      logic [WIDTH-1:0] g, e, ref_d;
      int nacc;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(a, f, g, e, o);
         tests++; if (f && g !== e) begin fails++; $display("FAIL drain_data got=%h exp=%h", g, e); end
      end
      tests++; if (sb.size() != 0 || bus.valid_o !== 1'b0) begin
         fails++; $display("FAIL drain_empty got=%0d/%b exp=0/0", sb.size(), bus.valid_o);
      end
      nacc = 0;
      have_ref = 1'b0;
      ref_d = '0;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         bus.din = WIDTH'($urandom);
         tick(a, f, g, e, o);
         if (a) nacc++;
         if (bus.valid_o) begin
            if (have_ref) begin
               tests++; if (bus.dout !== ref_d) begin fails++; $display("FAIL stall_dout_stable got=%h exp=%h", bus.dout, ref_d); end
            end else begin
               have_ref = 1'b1;
               ref_d = bus.dout;
            end
         end
      end
      tests++; if (nacc != CAP) begin fails++; $display("FAIL stall_accept_count got=%0d exp=%0d", nacc, CAP); end
      tests++; if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL stall_ready_o got=%b exp=0", bus.ready_o); end
      tests++; if (bus.valid_o !== 1'b1 || bus.dout !== sb[0]) begin
         fails++; $display("FAIL stall_head got=%b/%h exp=1/%h", bus.valid_o, bus.dout, sb[0]);
      end
      bus.ready_i = 1'b1;
      for (int i = 0; i < 2 && bus.ready_o !== 1'b1; i++) begin
         bus.din = WIDTH'($urandom);
         tick(a, f, g, e, o);
         tests++; if (f !== 1'b1 || g !== e) begin fails++; $display("FAIL release_data fired=%b got=%h exp=%h", f, g, e); end
      end
      tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL release_ready_o got=%b exp=1", bus.ready_o); end
      for (int i = 0; i < 12; i++) begin
         bus.din = WIDTH'($urandom);
         tick(a, f, g, e, o);
         tests++; if (f !== 1'b1 || g !== e) begin fails++; $display("FAIL release_stream cyc=%0d fired=%b got=%h exp=%h", i, f, g, e); end
      end
   endtask

   task automatic test_bubbles();
      bit a, f, o;
      logic [WIDTH-1:0] g, e;
      bus.ready_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         bus.valid_i = 1'($urandom);
         bus.din = bus.valid_i ? WIDTH'($urandom) : 'x;
         tick(a, f, g, e, o);
         tests++; if (o) begin fails++; $display("FAIL bubble_orphan cyc=%0d valid_o=1 exp=no pending word", i); end
         tests++; if (f && g !== e) begin fails++; $display("FAIL bubble_data cyc=%0d got=%h exp=%h", i, g, e); end
      end
      bus.valid_i = 1'b0;
      repeat (6) begin
         tick(a, f, g, e, o);
         tests++; if (f && g !== e) begin fails++; $display("FAIL bubble_drain got=%h exp=%h", g, e); end
      end
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL bubble_leftover got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_random();
      bit a, f, o;
      logic [WIDTH-1:0] g, e;
      max_occ = 0;
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            #2 rst = 1'b0;
            bus.valid_i = 1'b1;
            #1;
            tests++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.dout !== '0) begin
               fails++; $display("FAIL midreset_clear got=%b/%b/%h exp=0/1/00", bus.valid_o, bus.ready_o, bus.dout);
            end
            sb.delete();
            @(posedge clk);
            #2;
            tests++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
               fails++; $display("FAIL midreset_hold got=%b/%b exp=0/1", bus.valid_o, bus.ready_o);
            end
            rst = 1'b1;
         end
         bus.valid_i = ($urandom_range(3) != 0);
         bus.ready_i = ($urandom_range(2) != 0);
         bus.din = WIDTH'($urandom);
         tick(a, f, g, e, o);
         tests++; if (o) begin fails++; $display("FAIL rand_orphan cyc=%0d valid_o=1 exp=no pending word", i); end
         tests++; if (f && g !== e) begin fails++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, g, e); end
         tests++; if (sb.size() > CAP) begin fails++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp<=%0d", i, sb.size(), CAP); end
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      repeat (6) begin
         tick(a, f, g, e, o);
         tests++; if (f && g !== e) begin fails++; $display("FAIL rand_drain got=%h exp=%h", g, e); end
      end
      tests++; if (sb.size() != 0 || bus.valid_o !== 1'b0) begin
         fails++; $display("FAIL rand_leftover got=%0d/%b exp=0/0", sb.size(), bus.valid_o);
      end
      tests++; if (max_occ != CAP) begin fails++; $display("FAIL rand_max_occupancy got=%0d exp=%0d", max_occ, CAP); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall_release();
      test_bubbles();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
